// File: rtl/div_if.sv
// Operand/result bundle for the sequential divider: operands and start in,
// ready/err flags and registered quotient/remainder out.
interface div_if #(
  parameter int W = 8
);
  logic [2*W-1:0] a_bi;
  logic [W-1:0]   b_bi;
  logic           start_i;
  logic           ready_o;
  logic           err_o;
  logic [2*W-1:0] y_bo;
  logic [W-1:0]   r_bo;

  modport master (
    output a_bi, b_bi, start_i,
    input  ready_o, err_o, y_bo, r_bo
  );

  modport slave (
    input  a_bi, b_bi, start_i,
    output ready_o, err_o, y_bo, r_bo
  );
endinterface

// File: rtl/div.sv
// Restoring divider, one quotient bit per clock: 2W-bit dividend / W-bit divisor.
// Optional DIV_EARLY_EXIT_EN: answer a < b at the acceptance edge instead of iterating.
//
// state | meaning
// IDLE  | waiting for start_i, outputs hold last result
// WORK  | iterating, one quotient bit per edge
// READY | result valid on y_bo/r_bo/err_o; start_i restarts
module div #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  div_if.slave bus
);
  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0] CTR_LAST = CW'(2*W-1);

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WORK, READY} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] q_q, q_d;
  logic [W-1:0]   d_q, d_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  ctr_q, ctr_d;
  logic [2*W-1:0] y_q, y_d;
  logic [W-1:0]   r_q, r_d;
  logic           err_q, err_d;

  logic [W:0]     s, t, rem_next;
  logic [2*W-1:0] q_shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      ctr_q   <= '0;
      y_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      ctr_q   <= ctr_d;
      y_q     <= y_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    rem_d   = rem_q;
    ctr_d   = ctr_q;
    y_d     = y_q;
    r_d     = r_q;
    err_d   = err_q;

    // Trial subtraction: a set MSB of t means the divisor did not fit.
    s        = {rem_q[W-1:0], q_q[2*W-1]};
    t        = s - {1'b0, d_q};
    q_shift  = {q_q[2*W-2:0], ~t[W]};
    rem_next = t[W] ? s : t;

    case (state_q)
      IDLE, READY: begin
        if (bus.start_i) begin
          q_d   = bus.a_bi;
          d_d   = bus.b_bi;
          rem_d = '0;
          ctr_d = '0;
          if (bus.b_bi == '0) begin
            state_d = READY;
            y_d     = '1;
            r_d     = '0;
            err_d   = 1'b1;
          end else if (EarlyExit && (bus.a_bi < {{W{1'b0}}, bus.b_bi})) begin
            state_d = READY;
            y_d     = '0;
            r_d     = bus.a_bi[W-1:0];
            err_d   = 1'b0;
          end else begin
            state_d = WORK;
            err_d   = 1'b0;
          end
        end
      end
      WORK: begin
        q_d   = q_shift;
        rem_d = rem_next;
        ctr_d = ctr_q + CW'(1);
        if (ctr_q == CTR_LAST) begin
          y_d     = q_shift;
          r_d     = rem_next[W-1:0];
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == READY);
  assign bus.err_o   = err_q;
  assign bus.y_bo    = y_q;
  assign bus.r_bo    = r_q;
endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: stimulus pushes expected results into a
// scoreboard queue; a negedge monitor pops and compares each new result.
module tb_div;
  localparam int W = 8;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    int a;
    int b;
    int y;
    int r;
    int err;
    int exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  div_if #(.W(W)) bus ();

  div #(.W(W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // A new result is on the outputs when ready rises, or when a start was
  // accepted from READY and ready stayed high (zero-divisor restart).
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.ready_o && (!ready_prev || bus.start_i)) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y_bo", bus.y_bo, e.y);
        check("r_bo", bus.r_bo, e.r);
        check("err_o", bus.err_o, e.err);
        check("latency_cycle", cyc, e.exp_cyc);
        if (e.err == 0) begin
          check("invariant_a_eq_yb_plus_r", longint'(bus.y_bo) * e.b + bus.r_bo, e.a);
          check("invariant_r_lt_b", (int'(bus.r_bo) < e.b) ? 1 : 0, 1);
        end
      end
    end
    ready_prev <= rst ? 1'b0 : bus.ready_o;
  end

  function automatic int lat_of(input int a, input int b);
    if (b == 0) return 0;
    if (EARLY && a < b) return 0;
    return 2*W;
  endfunction

  task automatic do_op(input int a, input int b, input int y, input int r, input int err);
    exp_t e;
    @(negedge clk); #1;
    bus.a_bi    = a[2*W-1:0];
    bus.b_bi    = b[W-1:0];
    bus.start_i = 1'b1;
    e = '{a: a, b: b, y: y, r: r, err: err, exp_cyc: cyc + 1 + lat_of(a, b)};
    sb.push_back(e);
    @(negedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  int vec[5][4] = '{
    '{0,     5,   0,     0},
    '{65535, 1,   65535, 0},
    '{255,   255, 1,     0},
    '{40000, 200, 200,   0},
    '{1234,  56,  22,    2}
  };

  initial begin
    int c;
    exp_t e;
    bus.a_bi    = '0;
    bus.b_bi    = '0;
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready_o", bus.ready_o, 0);
    check("rst_y_bo", bus.y_bo, 0);
    check("rst_r_bo", bus.r_bo, 0);
    check("rst_err_o", bus.err_o, 0);
    #1 rst = 1'b0;

    do_op(200, 7, 28, 4, 0);                drain();
    do_op(65535, 255, 257, 0, 0);           drain();
    do_op(16'h1234, 1, 16'h1234, 0, 0);     drain();
    do_op(5, 0, 16'hFFFF, 0, 1);            drain();
    do_op(9, 4, 2, 1, 0);                   drain();
    for (int i = 0; i < 5; i++) begin
      do_op(vec[i][0], vec[i][1], vec[i][2], vec[i][3], 0);
      drain();
    end

    // Abort mid-operation: no result may appear, outputs cleared.
    @(negedge clk); #1;
    bus.a_bi = 16'd1000; bus.b_bi = 8'd3; bus.start_i = 1'b1;
    @(negedge clk); #1;
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_ready_o", bus.ready_o, 0);
    check("abort_y_bo", bus.y_bo, 0);
    check("abort_r_bo", bus.r_bo, 0);
    check("abort_err_o", bus.err_o, 0);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_result", bus.ready_o, 0);

    do_op(1000, 3, 333, 1, 0);              drain();

    // start_i held through WORK and into READY: back-to-back restart.
    @(negedge clk); #1;
    c = cyc;
    bus.a_bi = 16'd100; bus.b_bi = 8'd9; bus.start_i = 1'b1;
    e = '{a: 100, b: 9, y: 11, r: 1, err: 0, exp_cyc: c + 1 + 2*W};
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      bus.a_bi = bus.a_bi ^ 16'h5A5A;
      bus.b_bi = bus.b_bi ^ 8'h33;
    end
    @(negedge clk); #1;
    bus.a_bi = 16'd50; bus.b_bi = 8'd6;
    e = '{a: 50, b: 6, y: 8, r: 2, err: 0, exp_cyc: c + 2 + 2*2*W};
    sb.push_back(e);
    for (int n = 0; n < 40 && cyc < c + 2 + 2*W; n++) @(negedge clk);
    #1 bus.start_i = 1'b0;
    drain();

    do_op(3, 10, 0, 3, 0);                  drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential restoring divider; the inverse of the team's shift-add multiplier, sharing its start/ready handshake.
- Divides a 2W-bit dividend by a W-bit divisor and produces a 2W-bit quotient and a W-bit remainder.
- Processes one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and is driven by the same controller.

Parameters:
- W, 8, divisor/remainder width; dividend and quotient are 2W bits.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset; synchronous, active-high
- a_bi  input  2W  dividend, unsigned
- b_bi  input  W  divisor, unsigned
- start_i  input  1  start request
- ready_o  output  1  result valid; high exactly while state==READY
- err_o  output  1  divide-by-zero flag for the current result
- y_bo  output  2W  quotient, registered
- r_bo  output  W  remainder, registered

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state=IDLE, y_bo=0, r_bo=0, err_o=0, internal counter/accumulators=0.
  - Overrides everything, including mid-operation; an aborted division produces no result.
- States: IDLE, WORK, READY (2-bit encoding).
- IDLE, or READY with start_i=1:
  - Latch a_bi into quotient shift register q and b_bi into d; rem(W+1 bits)=0, ctr=0.
  - If b_bi==0: go to READY at this edge with y_bo={2W{1}}, r_bo=0, err_o=1; no WORK cycles.
  - Else: go to WORK, err_o=0. y_bo/r_bo keep their previous values until the new result.
- IDLE with start_i=0: hold.
- READY with start_i=0: hold outputs and state indefinitely.
- WORK, each edge:
  - s = {rem[W-1:0], q[2W-1]}, W+1 bits.
  - q shifts left by one.
  - t = s - {1'b0,d}.
  - If t is non-negative (MSB 0): rem=t and q[0]=1.
  - Else: rem=s and q[0]=0.
  - ctr increments.
- WORK, edge where ctr==2W-1:
  - Performs the final iteration.
  - Same edge: y_bo=final q, r_bo=final rem[W-1:0], state=READY.
- Latency for a nonzero divisor:
  - start_i sampled at edge 0; ready_o rises after edge 2W (16 for W=8).
  - Exactly 2W WORK cycles.
- Latency for a zero divisor: ready_o rises after edge 0.
- start_i is ignored in WORK; operands are latched only at acceptance, so a_bi/b_bi may change freely afterwards.
- Back-to-back: start_i held high in READY restarts immediately. ready_o drops after that edge, except for a zero divisor, where it stays high with the new result.
- Invariant (verification): a == y_bo*b + r_bo and r_bo < b whenever err_o=0.
- No overflow possible: the 2W-bit quotient covers the maximum dividend for b=1.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - At acceptance, if b_bi!=0 and a_bi < b_bi, skip WORK.
  - Go to READY at the acceptance edge with y_bo=0, r_bo=a_bi[W-1:0], err_o=0; latency 1 cycle.
  - a_bi < b_bi guarantees a_bi fits in W bits.
- Not defined:
  - Such operands take the normal 2W-cycle path.
  - Same final values: y_bo=0, r_bo=a_bi.

Test Plan:
- Reset, then a=200, b=7, start 1 cycle -> ready_o high 16 cycles after acceptance; y_bo=28, r_bo=4, err_o=0.
- a=65535, b=255 -> y_bo=257, r_bo=0. Then a=0x1234, b=1 -> y_bo=0x1234, r_bo=0.
- a=5, b=0 -> next cycle ready_o=1, err_o=1, y_bo=0xFFFF, r_bo=0. Then a=9, b=4 -> y_bo=2, r_bo=1, err_o=0.
- Start a=1000, b=3; assert rst_i at WORK cycle 8 -> next edge: IDLE, ready_o=0, y_bo=0, r_bo=0.
  - Then start a=1000, b=3 -> y_bo=333, r_bo=1.
- start_i held high through a full run with a=100, b=9 (y=11, r=1):
  - Toggling a_bi during WORK has no effect.
  - In READY, the held start launches a=50, b=6 -> y_bo=8, r_bo=2 after 16 more cycles.
- a=3, b=10:
  - With DIV_EARLY_EXIT_EN: ready_o after 1 cycle, y_bo=0, r_bo=3.
  - Without: ready_o after 16 cycles, same values.
